pipeline_wb_stage: RTL and testbench
====================================

// Module: pipeline_wb_stage
// PURPOSE
//  MEM/WB pipeline register plus write-back stage: drives the register-file write port of the decode stage.
//  Latches MEM-stage results and selects the write-back value (ALU / load data / PC+4 / immediate).
//  Suppresses writes to x0 and counts retired instructions.
//  Sits between the MEM stage and the decode stage's RegWrite/Rd_addr/Wt_data inputs.
// PARAMETERS
//  CNT_W    64   width of retired-instruction counter
//  XLEN     32   datapath width
// PORTS
//  clk_WB            in   1     clock; all state updates on rising edge
//  rst_WB            in   1     reset, synchronous, active-high
//  Stall_WB          in   1     hold MEM/WB register contents
//  Flush_WB          in   1     invalidate entry captured this edge
//  valid_in_WB       in   1     MEM stage holds a real instruction
//  RegWrite_in_WB    in   1     instruction writes rd
//  MemtoReg_in_WB    in   2     00 ALU, 01 load, 10 PC+4, 11 imm
//  Fun3_in_WB        in   3     load width/sign code
//  Rd_addr_in_WB     in   5     destination register
//  ALU_out_in_WB     in   XLEN  ALU result (also load byte address)
//  Mem_data_in_WB    in   XLEN  raw aligned data-memory word
//  PC4_in_WB         in   XLEN  PC+4 of the instruction
//  Imm_in_WB         in   XLEN  immediate (lui)
//  RegWrite_out_WB   out  1     register-file write enable to decode
//  Rd_addr_out_WB    out  5     register-file write address
//  Wt_data_out_WB    out  XLEN  register-file write data
//  Retire_WB         out  1     one-cycle pulse per retired instruction
//  Instret_WB        out  CNT_W retired-instruction count
// BEHAVIOUR
//  Reset: all registered fields 0, valid_q=0; outputs RegWrite_out=0, Rd_addr_out=0, Wt_data_out=0,
//   Retire=0, Instret=0. Reset overrides stall/flush; applies mid-stall and discards held entry.
//  Capture: on edge, if !Stall: reg <= inputs, valid_q <= valid_in & !Flush.
//   Flush has priority over Stall: valid_q <= 0 even when Stall=1; other fields may hold.
//  Latency: one cycle MEM->WB; outputs combinational from registered fields only (no in->out path).
//  RegWrite_out = valid_q & RegWrite_q & (Rd_q != 0); Rd_addr_out = Rd_q.
//  Wt_data_out: MemtoReg mux on registered fields; load path via load extender (below).
//  During Stall the same write is re-presented each cycle (idempotent); counted once.
//  Retire = valid_q & !Stall & !rst; Instret += Retire each edge, wraps all-ones -> 0 silently.
//  Flush and Stall both asserted with valid_q=1: held entry is dropped, not counted.
//  Fun3 values 011/110/111 on a load: treated as lw (word pass-through).
// CONFIGURATION
//  WB_LOAD_EXT_EN defined: sub-word loads by Fun3_q and ALU_q[1:0]:
//   000 lb sign-ext byte[off]; 100 lbu zero-ext byte[off]; 001 lh / 101 lhu use half[off[1]],
//   off[0] ignored; 010 lw word. Little-endian byte lanes.
//  Undefined: Mem_data_q passed unmodified for every load; Fun3 ignored.
// STRUCTURE
//  Package pipeline_pkg: MemtoReg codes (MTR_ALU/MTR_MEM/MTR_PC4/MTR_IMM), load Fun3 codes
//   (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU), XLEN default.
//  Sub-module load_extender (combinational: Fun3, byte offset, raw word -> extended data);
//   instantiated only under WB_LOAD_EXT_EN.
// TESTING
//  1 ALU write: valid,RegWrite,MemtoReg=00,rd=5,ALU=0x1234 -> next cycle RegWrite_out=1,Rd=5,Wt=0x1234,Retire=1.
//  2 x0 drop: rd=0, RegWrite=1 -> RegWrite_out=0; Retire=1, Instret increments.
//  3 Loads (EXT_EN): Mem=0x80FF7F01, lb off=2 -> 0xFFFFFFFF; lbu off=3 -> 0x80; lh off=2 -> 0xFFFF80FF; lw -> 0x80FF7F01.
//  4 Stall 3 cycles on held jal (MTR_PC4, PC4=0x104) -> Wt=0x104 all 3 cycles, Retire=0 while stalled, Instret +1 total.
//  5 Flush+Stall together on valid entry -> next cycle RegWrite_out=0, Retire=0, Instret unchanged.
//  6 Reset mid-stall, and Instret preloaded near all-ones -> after rst all outputs 0; wrap to 0 verified.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared encodings for the MEM/WB write-back stage.
//   mtr_e  : MemtoReg write-back source select.
//   f3_e   : load width/sign codes carried in Fun3.
//   XLEN_D : default datapath width.
package pipeline_pkg;

  localparam int XLEN_D = 32;

  typedef enum logic [1:0] {
    MTR_ALU = 2'b00,
    MTR_MEM = 2'b01,
    MTR_PC4 = 2'b10,
    MTR_IMM = 2'b11
  } mtr_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } f3_e;

endpackage

// File: rtl/pipeline_wb_stage_load_extender.sv
// load_extender: combinational sub-word load alignment and extension.
//   fun3_i : load width/sign code (unlisted codes behave as lw)
//   off_i  : byte offset within the word (ALU result [1:0])
//   word_i : raw aligned memory word, little-endian byte lanes
//   data_o : extended result
// Only instantiated when WB_LOAD_EXT_EN is defined.
module load_extender
  import pipeline_pkg::*;
#(
  parameter int XLEN = XLEN_D
) (
  input  logic [2:0]      fun3_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[8*off_i +: 8];
    // Halfword alignment uses off[1] only; off[0] is ignored.
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    data_o   = word_i;
    case (fun3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/pipeline_wb_stage.sv
// pipeline_wb_stage: MEM/WB pipeline register and write-back select.
//   Inputs *_in_WB  : MEM-stage instruction fields, captured on clk_WB unless Stall_WB.
//   Stall_WB        : hold the register; the held write is re-presented each cycle.
//   Flush_WB        : invalidate the entry held after this edge (wins over stall).
//   RegWrite/Rd/Wt  : register-file write port toward decode, driven from flops only.
//   Retire_WB       : one pulse per instruction leaving WB; Instret_WB counts them (wraps).
// Build option: define WB_LOAD_EXT_EN to enable lb/lbu/lh/lhu extension; otherwise
// loads write the raw memory word and Fun3 is ignored.
module pipeline_wb_stage
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 64,
  parameter int XLEN  = XLEN_D
) (
  input  logic             clk_WB,
  input  logic             rst_WB,
  input  logic             Stall_WB,
  input  logic             Flush_WB,
  input  logic             valid_in_WB,
  input  logic             RegWrite_in_WB,
  input  logic [1:0]       MemtoReg_in_WB,
  input  logic [2:0]       Fun3_in_WB,
  input  logic [4:0]       Rd_addr_in_WB,
  input  logic [XLEN-1:0]  ALU_out_in_WB,
  input  logic [XLEN-1:0]  Mem_data_in_WB,
  input  logic [XLEN-1:0]  PC4_in_WB,
  input  logic [XLEN-1:0]  Imm_in_WB,
  output logic             RegWrite_out_WB,
  output logic [4:0]       Rd_addr_out_WB,
  output logic [XLEN-1:0]  Wt_data_out_WB,
  output logic             Retire_WB,
  output logic [CNT_W-1:0] Instret_WB
);

  typedef struct packed {
    logic            regwrite;
    logic [1:0]      mtr;
    logic [2:0]      fun3;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] mem;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] imm;
  } wb_ent_t;

  wb_ent_t          ent_d, ent_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] instret_d, instret_q;
  logic [XLEN-1:0]  load_data;

  // A held entry retires only when it actually leaves WB (not stalled).
  assign Retire_WB = valid_q & ~Stall_WB & ~rst_WB;

  always_comb begin
    ent_d   = ent_q;
    valid_d = valid_q & ~Flush_WB;
    if (!Stall_WB) begin
      ent_d.regwrite = RegWrite_in_WB;
      ent_d.mtr      = MemtoReg_in_WB;
      ent_d.fun3     = Fun3_in_WB;
      ent_d.rd       = Rd_addr_in_WB;
      ent_d.alu      = ALU_out_in_WB;
      ent_d.mem      = Mem_data_in_WB;
      ent_d.pc4      = PC4_in_WB;
      ent_d.imm      = Imm_in_WB;
      valid_d        = valid_in_WB & ~Flush_WB;
    end
    instret_d = instret_q + CNT_W'(Retire_WB);
  end

  always_ff @(posedge clk_WB) begin
    if (rst_WB) begin
      ent_q     <= '0;
      valid_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      ent_q     <= ent_d;
      valid_q   <= valid_d;
      instret_q <= instret_d;
    end
  end

`ifdef WB_LOAD_EXT_EN
  load_extender #(.XLEN(XLEN)) u_load_ext (
    .fun3_i (ent_q.fun3),
    .off_i  (ent_q.alu[1:0]),
    .word_i (ent_q.mem),
    .data_o (load_data)
  );
`else
  logic unused_fun3;
  assign unused_fun3 = ^ent_q.fun3;
  assign load_data   = ent_q.mem;
`endif

  always_comb begin
    Wt_data_out_WB = ent_q.alu;
    case (ent_q.mtr)
      MTR_ALU: Wt_data_out_WB = ent_q.alu;
      MTR_MEM: Wt_data_out_WB = load_data;
      MTR_PC4: Wt_data_out_WB = ent_q.pc4;
      MTR_IMM: Wt_data_out_WB = ent_q.imm;
      default: Wt_data_out_WB = ent_q.alu;
    endcase
  end

  // Writes to x0 are suppressed but the instruction still retires.
  assign RegWrite_out_WB = valid_q & ent_q.regwrite & (ent_q.rd != 5'd0);
  assign Rd_addr_out_WB  = ent_q.rd;
  assign Instret_WB      = instret_q;

endmodule

// File: tb/tb_pipeline_wb_stage.sv
module tb_pipeline_wb_stage;

  localparam int CNT_W = 4;   // small counter so wraparound is reachable

  logic        clk = 1'b0;
  logic        rst, stall, flush, vin, rwin;
  logic [1:0]  mtr;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] alu, mem, pc4, imm;
  logic        rw_o, ret_o;
  logic [4:0]  rd_o;
  logic [31:0] wt_o;
  logic [CNT_W-1:0] cnt_o;

  int checks = 0;
  int errors = 0;

  // reference state: the instruction sitting in WB and the retire count
  bit          m_valid, m_rw;
  int unsigned m_mtr, m_f3, m_rd, m_alu, m_mem, m_pc4, m_imm, m_cnt;

  always #5 clk = ~clk;

  pipeline_wb_stage #(.CNT_W(CNT_W), .XLEN(32)) dut (
    .clk_WB(clk), .rst_WB(rst), .Stall_WB(stall), .Flush_WB(flush),
    .valid_in_WB(vin), .RegWrite_in_WB(rwin), .MemtoReg_in_WB(mtr),
    .Fun3_in_WB(f3), .Rd_addr_in_WB(rd), .ALU_out_in_WB(alu),
    .Mem_data_in_WB(mem), .PC4_in_WB(pc4), .Imm_in_WB(imm),
    .RegWrite_out_WB(rw_o), .Rd_addr_out_WB(rd_o), .Wt_data_out_WB(wt_o),
    .Retire_WB(ret_o), .Instret_WB(cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned load_val(int unsigned f, int unsigned a, int unsigned w);
    int unsigned b, h;
`ifdef WB_LOAD_EXT_EN
    b = (w >> (8 * (a % 4))) % 256;
    h = (w >> (16 * ((a % 4) / 2))) % 65536;
    case (f)
      0: return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
      4: return b;
      1: return (h >= 32768) ? (h + 32'hFFFF_0000) : h;
      5: return h;
      default: return w;
    endcase
`else
    return w;
`endif
  endfunction

  function automatic int unsigned exp_wt();
    case (m_mtr)
      0: return m_alu;
      1: return load_val(m_f3, m_alu, m_mem);
      2: return m_pc4;
      default: return m_imm;
    endcase
  endfunction

  // Called just after a negedge with inputs already driven: compare outputs with the
  // reference, take the rising edge, advance the reference.
  task automatic tick();
    bit exp_ret;
    #1;
    exp_ret = m_valid && !stall && !rst;
    chk("regwrite", rw_o, m_valid && m_rw && (m_rd != 0));
    chk("rd", rd_o, m_rd);
    chk("wt", wt_o, exp_wt());
    chk("retire", ret_o, exp_ret);
    chk("instret", cnt_o, m_cnt);
    @(posedge clk);
    if (rst) begin
      {m_valid, m_rw} = '0;
      {m_mtr, m_f3, m_rd, m_alu, m_mem, m_pc4, m_imm, m_cnt} = '0;
    end else begin
      m_cnt = (m_cnt + exp_ret) % (1 << CNT_W);
      if (!stall) begin
        m_valid = vin && !flush;
        m_rw = rwin; m_mtr = mtr; m_f3 = f3; m_rd = rd;
        m_alu = alu; m_mem = mem; m_pc4 = pc4; m_imm = imm;
      end else if (flush) m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    {stall, flush, vin, rwin} = '0;
    mtr = 0; f3 = 0; rd = 0; alu = 0; mem = 0; pc4 = 0; imm = 0;
  endtask

  task automatic issue(input bit rw_i, input logic [1:0] mtr_i, input logic [2:0] f3_i,
                       input logic [4:0] rd_i, input logic [31:0] alu_i, input logic [31:0] mem_i,
                       input logic [31:0] pc4_i, input logic [31:0] imm_i);
    vin = 1; rwin = rw_i; mtr = mtr_i; f3 = f3_i; rd = rd_i;
    alu = alu_i; mem = mem_i; pc4 = pc4_i; imm = imm_i;
  endtask

  initial begin
    logic [31:0] ld_exp [4];
    logic [2:0]  ld_f3 [4];
    logic [31:0] ld_alu [4];
    rst = 1; idle();
    @(negedge clk);
    tick(); tick();
    rst = 0;
    tick();                                    // reset state, nothing captured yet

    // 1: ALU write
    issue(1, 2'b00, 3'b000, 5'd5, 32'h1234, 0, 0, 0); tick();
    idle(); #1;
    chk("t1_rw", rw_o, 1); chk("t1_rd", rd_o, 5); chk("t1_wt", wt_o, 32'h1234); chk("t1_ret", ret_o, 1);
    tick();

    // 2: write to x0 is dropped but still retires
    issue(1, 2'b00, 3'b000, 5'd0, 32'hDEAD, 0, 0, 0); tick();
    idle(); #1;
    chk("t2_rw", rw_o, 0); chk("t2_ret", ret_o, 1);
    tick();
    chk("t2_cnt", cnt_o, 4'd2);

    // 3: loads from 0x80FF7F01
`ifdef WB_LOAD_EXT_EN
    ld_exp = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h80FF_7F01};
`else
    ld_exp = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
`endif
    ld_f3  = '{3'b000, 3'b100, 3'b001, 3'b010};
    ld_alu = '{32'h1002, 32'h1003, 32'h1002, 32'h1000};
    for (int i = 0; i < 4; i++) begin
      issue(1, 2'b01, ld_f3[i], 5'd7, ld_alu[i], 32'h80FF_7F01, 0, 0); tick();
      idle(); #1;
      chk($sformatf("t3_load%0d", i), wt_o, ld_exp[i]);
      tick();
    end

    // 4: jal held for 3 stalled cycles
    issue(1, 2'b10, 3'b000, 5'd1, 32'h55, 0, 32'h104, 0); tick();
    begin
      logic [CNT_W-1:0] c0;
      c0 = cnt_o;
      issue(1, 2'b00, 3'b000, 5'd9, 32'h999, 0, 32'h999, 0); stall = 1;
      for (int i = 0; i < 3; i++) begin
        #1; chk("t4_wt_stall", wt_o, 32'h104); chk("t4_ret_stall", ret_o, 0);
        tick();
      end
      idle(); #1;
      chk("t4_wt_rel", wt_o, 32'h104); chk("t4_ret_rel", ret_o, 1);
      tick();
      chk("t4_cnt", cnt_o, c0 + 1'b1);
    end

    // 5: flush + stall on a valid entry
    issue(1, 2'b11, 3'b000, 5'd3, 0, 0, 0, 32'hABC00000); tick();
    begin
      logic [CNT_W-1:0] c0;
      c0 = cnt_o;
      stall = 1; flush = 1; tick();
      idle(); #1;
      chk("t5_rw", rw_o, 0); chk("t5_ret", ret_o, 0); chk("t5_cnt", cnt_o, c0);
      tick();
    end

    // 6: reset while stalled, then counter wrap
    issue(1, 2'b00, 3'b000, 5'd4, 32'h77, 0, 0, 0); tick();
    stall = 1; tick();
    rst = 1; tick();
    rst = 0; idle(); #1;
    chk("t6_rw", rw_o, 0); chk("t6_rd", rd_o, 0); chk("t6_wt", wt_o, 0);
    chk("t6_ret", ret_o, 0); chk("t6_cnt", cnt_o, 0);
    issue(1, 2'b00, 3'b000, 5'd2, 32'h1, 0, 0, 0);
    for (int i = 0; i < 16; i++) tick();
    idle(); #1;
    chk("t6_cnt_max", cnt_o, 4'hF); chk("t6_ret_last", ret_o, 1);
    tick();
    chk("t6_cnt_wrap", cnt_o, 4'h0);

    // randomized traffic against the reference
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      vin   = ($urandom_range(0, 4) != 0);
      rwin  = $urandom_range(0, 1);
      mtr   = 2'($urandom_range(0, 3));
      f3    = 3'($urandom_range(0, 7));
      rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      alu   = $urandom; mem = $urandom; pc4 = $urandom; imm = $urandom;
      tick();
    end
    rst = 0; idle(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
